mlp_epoch_sequencer: RTL and testbench

//  Drives the MLP core with a stored training set: presents samples, toggles training/eval

---
 rtl/mlp_epoch_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mlp_epoch_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_epoch_sequencer.sv
// Epoch sequencer: replays a stored training set into the MLP core,
// alternating TRAIN and EVAL passes and scoring EVAL predictions.
module mlp_epoch_sequencer #(
  parameter int inputs      = 2,
  parameter int outputs     = 1,
  parameter int MAX_SAMPLES = 16,
  parameter int HOLD        = 2,
  parameter int EPOCH_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_we,
  input  logic [$clog2(MAX_SAMPLES)-1:0] load_addr,
  input  real                            load_values [inputs],
  input  real                            load_expected [outputs],
  input  logic [$clog2(MAX_SAMPLES):0]   num_samples,
  input  logic [EPOCH_W-1:0]             num_epochs,
  input  real                            threshold,
  input  logic                           start,
  input  real                            prediction [outputs],
  output real                            values [inputs],
  output real                            expected [outputs],
  output logic                           training,
  output logic                           busy,
  output logic                           epoch_done,
  output logic [$clog2(MAX_SAMPLES):0]   correct,
  output logic [EPOCH_W-1:0]             epoch,
  output logic                           done
);

  localparam int AW = $clog2(MAX_SAMPLES);
  localparam int SW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, TRAIN, EVAL, FINISH} state_t;

  state_t               state;
  real                  bv [MAX_SAMPLES][inputs];
  real                  be [MAX_SAMPLES][outputs];
  logic [AW-1:0]        idx;
  logic [HW-1:0]        hold;
  logic [SW-1:0]        ns_q;
  logic [SW-1:0]        run;
  logic [EPOCH_W-1:0]   ne_q;
  real                  thr_q;

  logic [SW-1:0]        ns_eff;
  logic [SW-1:0]        run_nx;
  logic [AW-1:0]        idx_nx;
  logic [AW-1:0]        ld_idx;
  logic [EPOCH_W-1:0]   epoch_nx;
  logic                 last_hold;
  logic                 last_idx;
  logic                 hit;
  logic                 reload;
  real                  v0 [inputs];
  real                  e0 [outputs];

  always_comb begin
    ns_eff    = (num_samples > SW'(MAX_SAMPLES)) ? SW'(MAX_SAMPLES) : num_samples;
    idx_nx    = idx + 1'b1;
    last_hold = (hold == HW'(HOLD - 1));
    last_idx  = ({1'b0, idx} == ns_q - 1'b1);
    ld_idx    = last_idx ? '0 : idx_nx;
    epoch_nx  = (&epoch) ? epoch : epoch + 1'b1;
    hit       = 1'b1;
    for (int k = 0; k < outputs; k++)
      if ((prediction[k] < thr_q) != (expected[k] < thr_q))
        hit = 1'b0;
    run_nx = run + SW'(hit);
    reload = !(state == EVAL && last_idx && epoch_nx == ne_q);
    // a write in the start cycle must reach the first presented sample
    for (int i = 0; i < inputs; i++)
      v0[i] = (load_we && load_addr == '0) ? load_values[i] : bv[0][i];
    for (int k = 0; k < outputs; k++)
      e0[k] = (load_we && load_addr == '0) ? load_expected[k] : be[0][k];
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && load_we) begin
      for (int i = 0; i < inputs; i++)
        bv[load_addr][i] <= load_values[i];
      for (int k = 0; k < outputs; k++)
        be[load_addr][k] <= load_expected[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      hold       <= '0;
      run        <= '0;
      ns_q       <= '0;
      ne_q       <= '0;
      thr_q      <= 0.0;
      training   <= 1'b0;
      busy       <= 1'b0;
      epoch_done <= 1'b0;
      correct    <= '0;
      epoch      <= '0;
      done       <= 1'b0;
      for (int i = 0; i < inputs; i++)
        values[i] <= 0.0;
      for (int k = 0; k < outputs; k++)
        expected[k] <= 0.0;
    end else begin
      epoch_done <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ns_q  <= ns_eff;
            ne_q  <= num_epochs;
            thr_q <= threshold;
            epoch <= '0;
            busy  <= 1'b1;
            idx   <= '0;
            hold  <= '0;
            run   <= '0;
            if (ns_eff == '0 || num_epochs == '0) begin
              state   <= FINISH;
              correct <= '0;
            end else begin
              state    <= TRAIN;
              training <= 1'b1;
              for (int i = 0; i < inputs; i++)
                values[i] <= v0[i];
              for (int k = 0; k < outputs; k++)
                expected[k] <= e0[k];
            end
          end
        end
        TRAIN, EVAL: begin
          hold <= last_hold ? '0 : hold + 1'b1;
          if (last_hold) begin
            idx <= ld_idx;
            if (reload) begin
              for (int i = 0; i < inputs; i++)
                values[i] <= bv[ld_idx][i];
              for (int k = 0; k < outputs; k++)
                expected[k] <= be[ld_idx][k];
            end
            if (!last_idx) begin
              if (state == EVAL)
                run <= run_nx;
            end else if (state == TRAIN) begin
              state    <= EVAL;
              training <= 1'b0;
              run      <= '0;
            end else begin
              correct    <= run_nx;
              epoch      <= epoch_nx;
              epoch_done <= 1'b1;
              run        <= '0;
              if (epoch_nx == ne_q) begin
                state <= FINISH;
              end else begin
                state    <= TRAIN;
                training <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          training <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_epoch_sequencer.sv
// Directed bench for mlp_epoch_sequencer with a stub MLP whose
// prediction is derived from the presented expected label.
module tb_mlp_epoch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_we = 1'b0;
  logic [3:0]  load_addr = '0;
  real         load_values [2];
  real         load_expected [1];
  logic [4:0]  num_samples = '0;
  logic [15:0] num_epochs = '0;
  real         threshold = 0.5;
  logic        start = 1'b0;
  real         prediction [1];
  real         values [2];
  real         expected [1];
  logic        training;
  logic        busy;
  logic        epoch_done;
  logic [4:0]  correct;
  logic [15:0] epoch;
  logic        done;

  int vec = 0;
  int errs = 0;
  int pmode = 0;

  real xa [4] = '{0.0, 0.0, 1.0, 1.0};
  real xb [4] = '{0.0, 1.0, 0.0, 1.0};
  real xe [4] = '{0.0, 1.0, 1.0, 0.0};

  mlp_epoch_sequencer dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_values(load_values), .load_expected(load_expected),
    .num_samples(num_samples), .num_epochs(num_epochs),
    .threshold(threshold), .start(start), .prediction(prediction),
    .values(values), .expected(expected), .training(training),
    .busy(busy), .epoch_done(epoch_done), .correct(correct),
    .epoch(epoch), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    prediction[0] = 0.4;
    case (pmode)
      0: prediction[0] = expected[0];
      1: prediction[0] = 1.0 - expected[0];
      default: prediction[0] = 0.4;
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int a, input real v0, input real v1,
                      input real e);
    load_we = 1'b1;
    load_addr = 4'(a);
    load_values[0] = v0;
    load_values[1] = v1;
    load_expected[0] = e;
    tick();
    load_we = 1'b0;
  endtask

  task automatic load_xor();
    for (int i = 0; i < 4; i++)
      load(i, xa[i], xb[i], xe[i]);
  endtask

  task automatic go(input int ns, input int ne);
    num_samples = 5'(ns);
    num_epochs = 16'(ne);
    threshold = 0.5;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_epoch_done(input int limit, output int cyc);
    cyc = 0;
    while (epoch_done !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    load_values[0] = 0.0;
    load_values[1] = 0.0;
    load_expected[0] = 0.0;
    #2;
    vec++;
    if ({busy, training, done, epoch_done} !== 4'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, training, done, epoch_done});
    end
    vec++;
    if (correct !== 5'd0 || epoch !== 16'd0) begin
      errs++;
      $display("FAIL reset_counts got correct=%0d epoch=%0d want 0 0",
               correct, epoch);
    end
    vec++;
    if (values[0] != 0.0 || values[1] != 0.0 || expected[0] != 0.0) begin
      errs++;
      $display("FAIL reset_data got %f %f %f want 0 0 0",
               values[0], values[1], expected[0]);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_xor_sequence();
    int s;
    load_xor();
    pmode = 0;
    go(4, 1);
    for (int c = 0; c < 16; c++) begin
      s = (c % 8) / 2;
      vec++;
      if (training !== 1'(c < 8) || busy !== 1'b1 ||
          values[0] != xa[s] || values[1] != xb[s] ||
          expected[0] != xe[s]) begin
        errs++;
        $display("FAIL xor_seq c=%0d got tr=%b busy=%b v=%f,%f e=%f want tr=%b v=%f,%f e=%f",
                 c, training, busy, values[0], values[1], expected[0],
                 1'(c < 8), xa[s], xb[s], xe[s]);
      end
      tick();
    end
    vec++;
    if (epoch_done !== 1'b1 || epoch !== 16'd1 || correct !== 5'd4 ||
        done !== 1'b0) begin
      errs++;
      $display("FAIL xor_end got ed=%b epoch=%0d correct=%0d done=%b want 1 1 4 0",
               epoch_done, epoch, correct, done);
    end
    tick();
    vec++;
    if (done !== 1'b1 || busy !== 1'b0 || epoch_done !== 1'b0) begin
      errs++;
      $display("FAIL xor_done got done=%b busy=%b ed=%b want 1 0 0",
               done, busy, epoch_done);
    end
    tick();
    vec++;
    if (done !== 1'b0 || values[0] != 1.0 || values[1] != 1.0) begin
      errs++;
      $display("FAIL xor_after got done=%b v=%f,%f want 0 1,1",
               done, values[0], values[1]);
    end
  endtask

  task automatic test_scoring();
    int modes [3] = '{0, 1, 2};
    int want [3] = '{4, 0, 2};
    int cyc;
    for (int m = 0; m < 3; m++) begin
      pmode = modes[m];
      go(4, 1);
      run_to_epoch_done(40, cyc);
      vec++;
      if (cyc != 16 || correct !== 5'(want[m])) begin
        errs++;
        $display("FAIL score mode=%0d got cyc=%0d correct=%0d want 16 %0d",
                 modes[m], cyc, correct, want[m]);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_multi_epoch();
    int ed [8];
    int ned = 0;
    int nd = 0;
    pmode = 0;
    go(4, 3);
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (epoch_done === 1'b1 && ned < 8) begin
        ed[ned] = c;
        ned++;
      end
      if (done === 1'b1)
        nd++;
    end
    vec++;
    if (ned != 3 || nd != 1) begin
      errs++;
      $display("FAIL multi_count got ed=%0d done=%0d want 3 1", ned, nd);
    end else begin
      vec++;
      if (ed[0] != 16 || ed[1] != 32 || ed[2] != 48) begin
        errs++;
        $display("FAIL multi_spacing got %0d %0d %0d want 16 32 48",
                 ed[0], ed[1], ed[2]);
      end
    end
    vec++;
    if (epoch !== 16'd3 || busy !== 1'b0) begin
      errs++;
      $display("FAIL multi_end got epoch=%0d busy=%b want 3 0", epoch, busy);
    end
  endtask

  task automatic test_degenerate();
    int ns [2] = '{0, 4};
    int ne [2] = '{5, 0};
    int dc;
    logic tr_seen;
    pmode = 0;
    for (int t = 0; t < 2; t++) begin
      go(ns[t], ne[t]);
      dc = -1;
      tr_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (training === 1'b1)
          tr_seen = 1'b1;
        if (done === 1'b1 && dc < 0)
          dc = c;
        tick();
      end
      vec++;
      if (tr_seen !== 1'b0 || dc != 1 || correct !== 5'd0 ||
          busy !== 1'b0) begin
        errs++;
        $display("FAIL degenerate t=%0d got train=%b done_at=%0d correct=%0d busy=%b want 0 1 0 0",
                 t, tr_seen, dc, correct, busy);
      end
    end
  endtask

  task automatic test_clamp();
    int cyc;
    for (int i = 4; i < 16; i++)
      load(i, real'(i % 2), 0.0, real'(i % 2));
    pmode = 0;
    go(20, 1);
    run_to_epoch_done(100, cyc);
    vec++;
    if (cyc != 64 || correct !== 5'd16) begin
      errs++;
      $display("FAIL clamp got cyc=%0d correct=%0d want 64 16", cyc, correct);
    end
    tick();
    tick();
  endtask

  task automatic test_busy_ignore();
    int s;
    int nd = 0;
    pmode = 0;
    go(4, 1);
    for (int c = 0; c < 16; c++) begin
      s = (c % 8) / 2;
      vec++;
      if (training !== 1'(c < 8) || values[0] != xa[s] ||
          values[1] != xb[s] || expected[0] != xe[s]) begin
        errs++;
        $display("FAIL busy_seq c=%0d got tr=%b v=%f,%f e=%f want v=%f,%f e=%f",
                 c, training, values[0], values[1], expected[0],
                 xa[s], xb[s], xe[s]);
      end
      if (c == 3) begin
        start = 1'b1;
        load(1, 7.0, 7.0, 0.0);
        start = 1'b0;
      end else begin
        tick();
      end
      if (done === 1'b1)
        nd++;
    end
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1)
        nd++;
      tick();
    end
    vec++;
    if (nd != 1 || busy !== 1'b0 || correct !== 5'd4) begin
      errs++;
      $display("FAIL busy_end got done_count=%0d busy=%b correct=%0d want 1 0 4",
               nd, busy, correct);
    end
    go(4, 1);
    tick();
    tick();
    vec++;
    if (values[0] != 0.0 || values[1] != 1.0 || expected[0] != 1.0) begin
      errs++;
      $display("FAIL busy_buffer got v=%f,%f e=%f want 0,1 1",
               values[0], values[1], expected[0]);
    end
    for (int c = 0; c < 20; c++)
      tick();
  endtask

  task automatic test_start_with_load();
    int cyc;
    num_samples = 5'd4;
    num_epochs = 16'd1;
    start = 1'b1;
    load(0, 0.25, 0.75, 1.0);
    start = 1'b0;
    vec++;
    if (values[0] != 0.25 || values[1] != 0.75 || expected[0] != 1.0 ||
        training !== 1'b1) begin
      errs++;
      $display("FAIL start_load got v=%f,%f e=%f tr=%b want 0.25,0.75 1 1",
               values[0], values[1], expected[0], training);
    end
    run_to_epoch_done(40, cyc);
    tick();
    tick();
    load(0, 0.0, 0.0, 0.0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int nd = 0;
    pmode = 0;
    go(4, 1);
    for (int c = 0; c < 10; c++)
      tick();
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if ({busy, training, epoch_done, done} !== 4'b0 ||
        correct !== 5'd0 || epoch !== 16'd0 ||
        values[0] != 0.0 || values[1] != 0.0 || expected[0] != 0.0) begin
      errs++;
      $display("FAIL reset_mid got flags=%b correct=%0d epoch=%0d v=%f,%f e=%f want all zero",
               {busy, training, epoch_done, done}, correct, epoch,
               values[0], values[1], expected[0]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done === 1'b1)
        nd++;
    end
    rst = 1'b1;
    tick();
    vec++;
    if (nd != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_nodone got done_count=%0d busy=%b want 0 0", nd, busy);
    end
    load_xor();
    go(4, 1);
    run_to_epoch_done(40, cyc);
    vec++;
    if (cyc != 16 || correct !== 5'd4 || epoch !== 16'd1) begin
      errs++;
      $display("FAIL restart got cyc=%0d correct=%0d epoch=%0d want 16 4 1",
               cyc, correct, epoch);
    end
    tick();
    vec++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL restart_done got %b want 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_xor_sequence();
    test_scoring();
    test_multi_epoch();
    test_degenerate();
    test_clamp();
    test_busy_ignore();
    test_start_with_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
